pet_sprite_layer: RTL and testbench

//  Pixel source feeding video_driver: answers each (x,y) pixel request with r/g/b.

---
 rtl/pet_sprite_layer_if.sv | 24 ++
 rtl/pet_sprite_layer.sv | 160 ++++++++++++++++
 tb/tb_pet_sprite_layer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pet_sprite_layer_if.sv
// Sprite update bus between game logic and the sprite layer: the position/visibility
// handshake and the sprite RAM write port.
interface pet_sprite_layer_if #(
    parameter int ADDR_W = 10
);
    logic              pos_valid;
    logic [9:0]        pos_x;
    logic [8:0]        pos_y;
    logic              pos_en;
    logic              pos_ready;
    logic              spr_we;
    logic [ADDR_W-1:0] spr_addr;
    logic [23:0]       spr_data;

    modport master (
        output pos_valid, pos_x, pos_y, pos_en, spr_we, spr_addr, spr_data,
        input  pos_ready
    );

    modport slave (
        input  pos_valid, pos_x, pos_y, pos_en, spr_we, spr_addr, spr_data,
        output pos_ready
    );
endinterface

// File: rtl/pet_sprite_layer.sv
// Pet sprite layer: answers each (x,y) pixel request with sprite RAM or background colour
// after exactly two clocks; position updates are held pending until the next frame wrap.
module pet_sprite_layer #(
    parameter int          SPRITE_W  = 32,
    parameter int          SPRITE_H  = 32,
    parameter int          ADDR_W    = 10,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [23:0]       bg_color,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    pet_sprite_layer_if.slave upd
);
    localparam int              DEPTH   = SPRITE_W * SPRITE_H;
    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [10:0]     SPR_W_L = 11'(SPRITE_W);
    localparam logic [10:0]     SPR_H_L = 11'(SPRITE_H);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_t;

    upd_state_t       state_r;
    upd_state_t       state_nx_s;
    logic             capture_s;
    logic             apply_s;
    logic             wrap_s;
    logic             pos_ready_r;

    logic [8:0]       y_prev_r;
    logic [9:0]       act_x_r;
    logic [8:0]       act_y_r;
    logic             act_en_r;
    logic [9:0]       pend_x_r;
    logic [8:0]       pend_y_r;
    logic             pend_en_r;

    logic [10:0]      dx_s;
    logic [10:0]      dy_s;
    logic             inside_s;
    logic [IDX_W-1:0] rd_addr_s;
    logic             wr_ok_s;

    logic [23:0]      mem [0:DEPTH-1];
    logic [23:0]      ram_q_r;
    logic             inside_q_r;
    logic [23:0]      bg_q_r;
    logic [23:0]      rgb_r;

    // S0: sprite-relative offsets; a pixel left of or above the sprite underflows and is rejected
    always_comb begin
        dx_s     = {1'b0, x} - {1'b0, act_x_r};
        dy_s     = {2'b00, y} - {2'b00, act_y_r};
        inside_s = act_en_r && (x >= act_x_r) && (y >= act_y_r)
                   && (dx_s < SPR_W_L) && (dy_s < SPR_H_L);
        if (inside_s) begin
            rd_addr_s = IDX_W'(32'(dy_s) * 32'(SPRITE_W) + 32'(dx_s));
        end else begin
            rd_addr_s = '0;
        end
    end

    assign wrap_s  = (y < y_prev_r);
    assign wr_ok_s = upd.spr_we && ({1'b0, upd.spr_addr} < DEPTH_L);

    // Sprite RAM: one write and one registered read port, read-before-write on a collision
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok_s) begin
            mem[upd.spr_addr[IDX_W-1:0]] <= upd.spr_data;
        end
        ram_q_r <= mem[rd_addr_s];
    end

    // S1/S2 pipeline: select sprite data unless transparent or outside the sprite
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            inside_q_r <= 1'b0;
            bg_q_r     <= 24'h000000;
            rgb_r      <= 24'h000000;
        end else begin
            inside_q_r <= inside_s;
            bg_q_r     <= bg_color;
            if (inside_q_r && (ram_q_r != KEY_COLOR)) begin
                rgb_r <= ram_q_r;
            end else begin
                rgb_r <= bg_q_r;
            end
        end
    end

    assign r = rgb_r[23:16];
    assign g = rgb_r[15:8];
    assign b = rgb_r[7:0];

    // Update handshake next-state: capture in IDLE, commit to active only on a frame wrap
    always_comb begin
        state_nx_s = state_r;
        capture_s  = 1'b0;
        apply_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (upd.pos_valid) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_PENDING;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (wrap_s) begin
                    apply_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_PENDING;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Handshake state, frame-wrap tracking and the pending/active sprite placement
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pos_ready_r <= 1'b1;
            y_prev_r    <= 9'd0;
            act_x_r     <= 10'd0;
            act_y_r     <= 9'd0;
            act_en_r    <= 1'b0;
            pend_x_r    <= 10'd0;
            pend_y_r    <= 9'd0;
            pend_en_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            pos_ready_r <= (state_nx_s == ST_IDLE);
            y_prev_r    <= y;
            if (capture_s) begin
                pend_x_r  <= upd.pos_x;
                pend_y_r  <= upd.pos_y;
                pend_en_r <= upd.pos_en;
            end
            if (apply_s) begin
                act_x_r  <= pend_x_r;
                act_y_r  <= pend_y_r;
                act_en_r <= pend_en_r;
            end
        end
    end

    assign upd.pos_ready = pos_ready_r;
endmodule

// File: tb/tb_pet_sprite_layer.sv
// Self-checking bench for pet_sprite_layer: scoreboard of expected pixels popped two
// clocks after each request, a constant vector table, and hand-written handshake sequences.
module tb_pet_sprite_layer;
    localparam int          ADDR_W = 11;
    localparam logic [23:0] KEY    = 24'hFF00FF;
    localparam logic [23:0] BG     = 24'h102030;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] bg_color;
    logic [7:0]  r, g, b;

    pet_sprite_layer_if #(.ADDR_W(ADDR_W)) upd ();

    pet_sprite_layer #(
        .SPRITE_W (32),
        .SPRITE_H (32),
        .ADDR_W   (ADDR_W),
        .KEY_COLOR(KEY)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .x       (x),
        .y       (y),
        .bg_color(bg_color),
        .r       (r),
        .g       (g),
        .b       (b),
        .upd     (upd)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [23:0] rgb;
        string       nm;
    } sb_t;

    typedef struct {
        int          vx;
        int          vy;
        logic [23:0] exp;
    } vec_t;

    sb_t         sbq[$];
    vec_t        tbl[11];
    int          n_checks = 0;
    int          n_fail   = 0;

    // stimulus globals picked up by step()
    logic        vld_g = 1'b0;
    int          px_g = 0, py_g = 0;
    logic        pen_g = 1'b0;
    logic        we_g = 1'b0;
    int          waddr_g = 0;
    logic [23:0] wdata_g = 24'h000000;

    // reference model
    logic [23:0] ram_m [0:1023];
    int          ax_m = 0, ay_m = 0, ppx_m = 0, ppy_m = 0, yprev_m = 0;
    logic        aen_m = 1'b0, ppen_m = 1'b0, pend_m = 1'b0;

    function automatic logic [23:0] exp_pix(input int xi, input int yi);
        logic [23:0] d;
        if (aen_m && xi >= ax_m && yi >= ay_m && (xi - ax_m) < 32 && (yi - ay_m) < 32) begin
            d = ram_m[(yi - ay_m) * 32 + (xi - ax_m)];
            if (d != KEY) return d;
        end
        return BG;
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic step(input int xi, input int yi, input logic [23:0] expv, input string nm);
        sb_t  e;
        logic wrap;
        @(posedge CLOCK_50);
        #1;
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            chk(e.nm, {r, g, b}, e.rgb);
        end
        chk("pos_ready", {23'd0, upd.pos_ready}, {23'd0, ~pend_m});
        x             = 10'(xi);
        y             = 9'(yi);
        upd.pos_valid = vld_g;
        upd.pos_x     = 10'(px_g);
        upd.pos_y     = 9'(py_g);
        upd.pos_en    = pen_g;
        upd.spr_we    = we_g;
        upd.spr_addr  = 11'(waddr_g);
        upd.spr_data  = wdata_g;
        e.rgb = expv;
        e.nm  = nm;
        sbq.push_back(e);
        wrap    = (yi < yprev_m);
        yprev_m = yi;
        if (pend_m) begin
            if (wrap) begin
                ax_m = ppx_m; ay_m = ppy_m; aen_m = ppen_m; pend_m = 1'b0;
            end
        end else if (vld_g) begin
            ppx_m = px_g; ppy_m = py_g; ppen_m = pen_g; pend_m = 1'b1;
        end
        if (we_g && waddr_g < 1024) ram_m[waddr_g] = wdata_g;
    endtask

    task automatic px(input int xi, input int yi, input string nm);
        step(xi, yi, exp_pix(xi, yi), nm);
    endtask

    task automatic offer(input int nx, input int ny, input logic ne, input int xi, input int yi);
        px_g = nx; py_g = ny; pen_g = ne; vld_g = 1'b1;
        px(xi, yi, "offer");
        vld_g = 1'b0;
    endtask

    task automatic wr(input int a, input logic [23:0] d, input int xi, input int yi);
        we_g = 1'b1; waddr_g = a; wdata_g = d;
        px(xi, yi, "write");
        we_g = 1'b0;
    endtask

    task automatic frame_wrap();
        px(0, 479, "wrap_hi");
        px(0, 0, "wrap_lo");
    endtask

    initial begin
        tbl[0]  = '{100, 50, 24'hA00000};
        tbl[1]  = '{131, 81, 24'hA003FF};
        tbl[2]  = '{132, 50, BG};
        tbl[3]  = '{99, 50, BG};
        tbl[4]  = '{100, 49, BG};
        tbl[5]  = '{131, 50, 24'hA0001F};
        tbl[6]  = '{100, 81, 24'hA003E0};
        tbl[7]  = '{100, 82, BG};
        tbl[8]  = '{105, 50, BG};
        tbl[9]  = '{106, 50, 24'hA00006};
        tbl[10] = '{101, 51, 24'hA00021};

        x = 10'd0; y = 9'd0; bg_color = BG;
        upd.pos_valid = 1'b0; upd.pos_x = 10'd0; upd.pos_y = 9'd0; upd.pos_en = 1'b0;
        upd.spr_we = 1'b0; upd.spr_addr = 11'd0; upd.spr_data = 24'h000000;

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_rgb", {r, g, b}, 24'h000000);
        chk("reset_ready", {23'd0, upd.pos_ready}, 24'd1);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // hidden sprite: background only
        px(5, 3, "bg_a");
        px(300, 200, "bg_b");
        px(639, 479, "bg_c");
        px(100, 50, "bg_d");

        // fill RAM, then an out-of-range write and a colour-key entry
        for (int i = 0; i < 1024; i++) wr(i, 24'hA00000 + 24'(i), 0, 0);
        wr(1024, 24'h123456, 0, 0);
        wr(5, KEY, 0, 0);

        // mid-frame offer stays pending until wrap; a second offer is not accepted
        px(0, 10, "pre_offer");
        offer(100, 50, 1'b1, 0, 10);
        px(100, 50, "unmoved");
        offer(300, 300, 1'b1, 100, 60);
        px(100, 70, "still_pending");
        frame_wrap();

        for (int i = 0; i < 11; i++) step(tbl[i].vx, tbl[i].vy, tbl[i].exp, $sformatf("vec%0d", i));

        // read and write of the same address in one cycle returns old data
        we_g = 1'b1; waddr_g = 2; wdata_g = 24'h0F0F0F;
        step(102, 50, 24'hA00002, "rw_old");
        we_g = 1'b0;
        step(102, 50, 24'h0F0F0F, "rw_new");

        // offer coinciding with a wrap is applied at the following wrap
        px(0, 479, "pre_wrap");
        offer(200, 100, 1'b1, 0, 0);
        px(200, 100, "not_yet");
        px(100, 100, "old_pos");
        frame_wrap();
        px(200, 100, "applied");
        px(205, 100, "applied_key");

        // sprite hanging off the bottom-right corner
        offer(620, 470, 1'b1, 0, 100);
        frame_wrap();
        for (int i = 0; i < 12; i++) px(i, 0, "edge_y0");
        for (int i = 0; i < 12; i++) px(i, 1, "edge_y1");
        px(620, 470, "corner_tl");
        px(619, 470, "corner_left");
        px(639, 470, "corner_tr");
        px(620, 469, "corner_above");
        px(639, 479, "corner_br");
        px(0, 470, "corner_x0");

        // reset mid-frame with an update pending
        offer(0, 0, 1'b1, 10, 200);
        px(620, 475, "pre_reset");
        px(630, 476, "pre_reset2");
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_rgb", {r, g, b}, 24'h000000);
        chk("midreset_ready", {23'd0, upd.pos_ready}, 24'd1);
        sbq.delete();
        aen_m = 1'b0; ax_m = 0; ay_m = 0; pend_m = 1'b0; yprev_m = 0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #2;
        reset = 1'b0;
        px(620, 470, "hidden_a");
        frame_wrap();
        px(620, 470, "hidden_b");
        px(639, 479, "hidden_c");
        px(0, 0, "drain_a");
        px(0, 0, "drain_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
